// File: rtl/riscv_multicycle_control.sv
// Multi-cycle sequencer for the RISC-V integer datapath: fetch over a req/valid
// handshake, decode, then one EXECUTE cycle of datapath strobes per instruction.
module riscv_multicycle_control #(
    parameter int IMEM_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemReq,
    input  logic        imemValid,
    input  logic [31:0] imemRdata,
    input  logic        isZero,
    output logic [31:0] instr,
    output logic        regWrite,
    output logic [3:0]  aluControl,
    output logic        isALUreg,
    output logic        isShamt,
    output logic        pcWrite,
    output logic        pcSrcBranch,
    output logic        retired,
    output logic [31:0] instret,
    output logic [1:0]  fault
);

    typedef enum logic [1:0] {FETCH, DECODE, EXECUTE, TRAP} state_t;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    // The fetch faults in the cycle whose wait would bring the count to IMEM_TIMEOUT.
    localparam logic [15:0] WAIT_LIMIT = 16'(IMEM_TIMEOUT - 1);

    state_t      state, state_next;
    logic [15:0] wait_count;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       rd_nonzero;

    logic       dec_legal;
    logic [3:0] dec_alu;
    logic       dec_alureg;
    logic       dec_shamt;
    logic       dec_regwrite;
    logic       dec_branch;
    logic       dec_bne;

    logic [3:0] ctl_alu;
    logic       ctl_alureg;
    logic       ctl_shamt;
    logic       ctl_regwrite;
    logic       ctl_branch;
    logic       ctl_bne;

    assign opcode     = instr[6:0];
    assign funct3     = instr[14:12];
    assign funct7     = instr[31:25];
    assign rd_nonzero = (instr[11:7] != 5'd0);

    always_comb begin
        dec_legal    = 1'b0;
        dec_alu      = ALU_ADD;
        dec_alureg   = 1'b0;
        dec_shamt    = 1'b0;
        dec_regwrite = 1'b0;
        dec_branch   = 1'b0;
        dec_bne      = 1'b0;
        case (opcode)
            OPC_OP: begin
                dec_legal    = (funct7 == 7'b0000000) ||
                               (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101));
                dec_alureg   = 1'b1;
                dec_regwrite = rd_nonzero;
                case (funct3)
                    3'b000:  dec_alu = funct7[5] ? ALU_SUB : ALU_ADD;
                    3'b001:  dec_alu = ALU_SLL;
                    3'b010:  dec_alu = ALU_SLT;
                    3'b011:  dec_alu = ALU_SLTU;
                    3'b100:  dec_alu = ALU_XOR;
                    3'b101:  dec_alu = funct7[5] ? ALU_SRA : ALU_SRL;
                    3'b110:  dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
                dec_shamt = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            // For OP-IMM the upper bits are immediate except on the shift forms.
            OPC_OP_IMM: begin
                dec_legal    = 1'b1;
                dec_regwrite = rd_nonzero;
                case (funct3)
                    3'b000: dec_alu = ALU_ADD;
                    3'b001: begin
                        dec_alu   = ALU_SLL;
                        dec_legal = (funct7 == 7'b0000000);
                    end
                    3'b010: dec_alu = ALU_SLT;
                    3'b011: dec_alu = ALU_SLTU;
                    3'b100: dec_alu = ALU_XOR;
                    3'b101: begin
                        dec_alu   = funct7[5] ? ALU_SRA : ALU_SRL;
                        dec_legal = (funct7 == 7'b0000000) || (funct7 == 7'b0100000);
                    end
                    3'b110:  dec_alu = ALU_OR;
                    default: dec_alu = ALU_AND;
                endcase
                dec_shamt = (funct3 == 3'b001) || (funct3 == 3'b101);
            end
            OPC_BRANCH: begin
                dec_legal  = (funct3 == 3'b000) || (funct3 == 3'b001);
                dec_alu    = ALU_SUB;
                dec_alureg = 1'b1;
                dec_branch = 1'b1;
                dec_bne    = funct3[0];
            end
            default: dec_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= FETCH;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            instr        <= 32'd0;
            wait_count   <= 16'd0;
            fault        <= 2'b00;
            instret      <= 32'd0;
            ctl_alu      <= ALU_ADD;
            ctl_alureg   <= 1'b0;
            ctl_shamt    <= 1'b0;
            ctl_regwrite <= 1'b0;
            ctl_branch   <= 1'b0;
            ctl_bne      <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (imemValid) begin
                        instr      <= imemRdata;
                        wait_count <= 16'd0;
                    end else if (wait_count == WAIT_LIMIT) begin
                        fault      <= 2'b10;
                        wait_count <= 16'd0;
                    end else begin
                        wait_count <= wait_count + 16'd1;
                    end
                end
                DECODE: begin
                    ctl_alu      <= dec_alu;
                    ctl_alureg   <= dec_alureg;
                    ctl_shamt    <= dec_shamt;
                    ctl_regwrite <= dec_regwrite;
                    ctl_branch   <= dec_branch;
                    ctl_bne      <= dec_bne;
                    if (!dec_legal) begin
                        fault <= 2'b01;
                    end
                end
                EXECUTE: instret <= instret + 32'd1;
                default: ;
            endcase
        end
    end

    // Outputs stay quiet during the reset cycle regardless of the held state.
    always_comb begin
        state_next  = state;
        imemReq     = 1'b0;
        regWrite    = 1'b0;
        aluControl  = 4'b0000;
        isALUreg    = 1'b0;
        isShamt     = 1'b0;
        pcWrite     = 1'b0;
        pcSrcBranch = 1'b0;
        retired     = 1'b0;
        if (reset) begin
            case (state)
                FETCH: begin
                    imemReq = 1'b1;
                    if (imemValid) begin
                        state_next = DECODE;
                    end else if (wait_count == WAIT_LIMIT) begin
                        state_next = TRAP;
                    end
                end
                DECODE: state_next = dec_legal ? EXECUTE : TRAP;
                EXECUTE: begin
                    regWrite    = ctl_regwrite;
                    aluControl  = ctl_alu;
                    isALUreg    = ctl_alureg;
                    isShamt     = ctl_shamt;
                    pcWrite     = 1'b1;
                    pcSrcBranch = ctl_branch & (ctl_bne ? ~isZero : isZero);
                    retired     = 1'b1;
                    state_next  = FETCH;
                end
                default: state_next = TRAP;
            endcase
        end
    end

endmodule

// File: tb/tb_riscv_multicycle_control.sv
// Bench for riscv_multicycle_control: directed vector table, hand-written reset and
// timeout sequences, and random instructions checked against a pattern-table decoder.
module tb_riscv_multicycle_control;

    typedef struct {
        logic       legal;
        logic [3:0] alu;
        logic       alureg;
        logic       shamt;
        logic       rw;
        logic       pcsrc;
        logic       branch;
    } exp_t;

    typedef struct {
        logic [31:0] word;
        int          waits;
        logic        zero;
        exp_t        e;
    } vec_t;

    typedef struct {
        logic [6:0] opc;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       f7care;
        logic [3:0] alu;
    } pat_t;

    logic        clk;
    logic        reset, reset_t;
    logic        imemValid, valid_t;
    logic [31:0] imemRdata;
    logic        isZero;

    logic        imemReq, regWrite, isALUreg, isShamt, pcWrite, pcSrcBranch, retired;
    logic [3:0]  aluControl;
    logic [31:0] instr, instret;
    logic [1:0]  fault;

    logic        imemReq_t, regWrite_t, isALUreg_t, isShamt_t, pcWrite_t, pcSrcBranch_t, retired_t;
    logic [3:0]  aluControl_t;
    logic [31:0] instr_t, instret_t;
    logic [1:0]  fault_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_instret;
    logic [31:0] exp_instr;
    vec_t        vecs[$];
    pat_t        pats[$];

    riscv_multicycle_control dut (
        .clk(clk), .reset(reset), .imemReq(imemReq), .imemValid(imemValid),
        .imemRdata(imemRdata), .isZero(isZero), .instr(instr), .regWrite(regWrite),
        .aluControl(aluControl), .isALUreg(isALUreg), .isShamt(isShamt),
        .pcWrite(pcWrite), .pcSrcBranch(pcSrcBranch), .retired(retired),
        .instret(instret), .fault(fault)
    );

    riscv_multicycle_control #(.IMEM_TIMEOUT(4)) dut_to (
        .clk(clk), .reset(reset_t), .imemReq(imemReq_t), .imemValid(valid_t),
        .imemRdata(imemRdata), .isZero(isZero), .instr(instr_t), .regWrite(regWrite_t),
        .aluControl(aluControl_t), .isALUreg(isALUreg_t), .isShamt(isShamt_t),
        .pcWrite(pcWrite_t), .pcSrcBranch(pcSrcBranch_t), .retired(retired_t),
        .instret(instret_t), .fault(fault_t)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, {31'b0, actual}, {31'b0, expected});
    endtask

    task automatic checkIdle(input string tag);
        checkBit({tag, ".regWrite"}, regWrite, 1'b0);
        checkBit({tag, ".pcWrite"}, pcWrite, 1'b0);
        checkBit({tag, ".pcSrcBranch"}, pcSrcBranch, 1'b0);
        checkBit({tag, ".retired"}, retired, 1'b0);
        checkBit({tag, ".isALUreg"}, isALUreg, 1'b0);
        checkBit({tag, ".isShamt"}, isShamt, 1'b0);
        checkOutput({tag, ".aluControl"}, {28'b0, aluControl}, 32'd0);
    endtask

    // Reset cycle only; the caller's next cycle releases reset.
    task automatic doReset();
        @(negedge clk);
        reset = 1'b0;
        imemValid = 1'($urandom_range(0, 1));
        #1;
        checkBit("rst.imemReq", imemReq, 1'b0);
        checkIdle("rst");
        exp_instret = 32'd0;
        exp_instr = 32'd0;
    endtask

    function automatic exp_t refDecode(input logic [31:0] w, input logic zero);
        exp_t r;
        r = '{legal: 1'b0, alu: 4'd0, alureg: 1'b0, shamt: 1'b0, rw: 1'b0, pcsrc: 1'b0, branch: 1'b0};
        foreach (pats[i]) begin
            if (pats[i].opc == w[6:0] && pats[i].f3 == w[14:12] &&
                (!pats[i].f7care || pats[i].f7 == w[31:25])) begin
                r.legal  = 1'b1;
                r.alu    = pats[i].alu;
                r.branch = (w[6:0] == 7'h63);
                r.alureg = (w[6:0] != 7'h13);
                r.shamt  = (r.alu == 4'd2) || (r.alu == 4'd6) || (r.alu == 4'd7);
                r.rw     = !r.branch && (w[11:7] != 5'd0);
                r.pcsrc  = r.branch && (w[12] ? !zero : zero);
            end
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic [31:0] word, input int waits, input logic zero, input exp_t e);
        for (int i = 0; i <= waits; i++) begin
            @(negedge clk);
            reset = 1'b1;
            imemValid = (i == waits);
            imemRdata = (i == waits) ? word : $urandom;
            isZero = 1'($urandom_range(0, 1));
            #1;
            checkBit("fetch.imemReq", imemReq, 1'b1);
            checkOutput("fetch.instr", instr, exp_instr);
            checkOutput("fetch.instret", instret, exp_instret);
            checkOutput("fetch.fault", {30'b0, fault}, 32'd0);
            checkIdle("fetch");
        end
        exp_instr = word;
        @(negedge clk);
        imemValid = 1'($urandom_range(0, 1));
        imemRdata = $urandom;
        isZero = zero;
        #1;
        checkBit("decode.imemReq", imemReq, 1'b0);
        checkOutput("decode.instr", instr, word);
        checkIdle("decode");
        @(negedge clk);
        imemValid = 1'($urandom_range(0, 1));
        #1;
        if (e.legal) begin
            checkBit("exec.imemReq", imemReq, 1'b0);
            checkOutput("exec.aluControl", {28'b0, aluControl}, {28'b0, e.alu});
            checkBit("exec.isALUreg", isALUreg, e.alureg);
            checkBit("exec.isShamt", isShamt, e.shamt);
            checkBit("exec.regWrite", regWrite, e.rw);
            checkBit("exec.pcWrite", pcWrite, 1'b1);
            checkBit("exec.retired", retired, 1'b1);
            checkBit("exec.pcSrcBranch", pcSrcBranch, e.pcsrc);
            checkOutput("exec.fault", {30'b0, fault}, 32'd0);
            checkOutput("exec.instr", instr, word);
            if (e.branch) begin
                isZero = ~zero;
                #1;
                checkBit("exec.pcSrcBranch.flip", pcSrcBranch, ~e.pcsrc);
            end
            exp_instret = exp_instret + 32'd1;
        end else begin
            for (int k = 0; k < 3; k++) begin
                checkOutput("trap.fault", {30'b0, fault}, 32'd1);
                checkBit("trap.imemReq", imemReq, 1'b0);
                checkOutput("trap.instret", instret, exp_instret);
                checkIdle("trap");
                @(negedge clk);
                imemValid = 1'b1;
                #1;
            end
            doReset();
        end
    endtask

    task automatic addPat(input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                          input logic f7care, input logic [3:0] alu);
        pat_t p;
        p = '{opc: opc, f3: f3, f7: f7, f7care: f7care, alu: alu};
        pats.push_back(p);
    endtask

    task automatic addVec(input logic [31:0] word, input int waits, input logic zero,
                          input logic legal, input logic [3:0] alu, input logic alureg,
                          input logic shamt, input logic rw, input logic pcsrc, input logic branch);
        vec_t v;
        v.word = word;
        v.waits = waits;
        v.zero = zero;
        v.e = '{legal: legal, alu: alu, alureg: alureg, shamt: shamt, rw: rw, pcsrc: pcsrc, branch: branch};
        vecs.push_back(v);
    endtask

    initial begin
        reset = 1'b0; reset_t = 1'b0;
        imemValid = 1'b0; valid_t = 1'b0;
        imemRdata = 32'd0; isZero = 1'b0;
        exp_instret = 32'd0; exp_instr = 32'd0;

        // Legal encodings of the supported RV32I subset
        addPat(7'h33, 3'd0, 7'h00, 1'b1, 4'd0); addPat(7'h33, 3'd0, 7'h20, 1'b1, 4'd1);
        addPat(7'h33, 3'd1, 7'h00, 1'b1, 4'd2); addPat(7'h33, 3'd2, 7'h00, 1'b1, 4'd3);
        addPat(7'h33, 3'd3, 7'h00, 1'b1, 4'd4); addPat(7'h33, 3'd4, 7'h00, 1'b1, 4'd5);
        addPat(7'h33, 3'd5, 7'h00, 1'b1, 4'd6); addPat(7'h33, 3'd5, 7'h20, 1'b1, 4'd7);
        addPat(7'h33, 3'd6, 7'h00, 1'b1, 4'd8); addPat(7'h33, 3'd7, 7'h00, 1'b1, 4'd9);
        addPat(7'h13, 3'd0, 7'h00, 1'b0, 4'd0); addPat(7'h13, 3'd1, 7'h00, 1'b1, 4'd2);
        addPat(7'h13, 3'd2, 7'h00, 1'b0, 4'd3); addPat(7'h13, 3'd3, 7'h00, 1'b0, 4'd4);
        addPat(7'h13, 3'd4, 7'h00, 1'b0, 4'd5); addPat(7'h13, 3'd5, 7'h00, 1'b1, 4'd6);
        addPat(7'h13, 3'd5, 7'h20, 1'b1, 4'd7); addPat(7'h13, 3'd6, 7'h00, 1'b0, 4'd8);
        addPat(7'h13, 3'd7, 7'h00, 1'b0, 4'd9);
        addPat(7'h63, 3'd0, 7'h00, 1'b0, 4'd1); addPat(7'h63, 3'd1, 7'h00, 1'b0, 4'd1);

        //     word          waits zero  legal alu    alureg shamt rw  pcsrc branch
        addVec(32'h002081B3, 0, 1'b0, 1'b1, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec(32'h4030D093, 4, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(32'h00208463, 1, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        addVec(32'h00208463, 0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        addVec(32'h00209463, 2, 1'b1, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        addVec(32'h00209463, 0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
        addVec(32'h00000013, 0, 1'b0, 1'b1, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(32'h402081B3, 0, 1'b0, 1'b1, 4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec(32'h002091B3, 3, 1'b0, 1'b1, 4'h2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        addVec(32'hFFF0F193, 0, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec(32'h0020C1B3, 1, 1'b0, 1'b1, 4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        addVec(32'h0000007F, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(32'h402091B3, 0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(32'h40209193, 2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        addVec(32'h0020A463, 0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        doReset();
        foreach (vecs[i]) begin
            applyStimulus(vecs[i].word, vecs[i].waits, vecs[i].zero, vecs[i].e);
        end

        // Reset landing in DECODE must not retire or update the PC
        @(negedge clk);
        reset = 1'b1; imemValid = 1'b1; imemRdata = 32'h002081B3;
        #1;
        checkBit("rstdec.fetch.imemReq", imemReq, 1'b1);
        @(negedge clk);
        reset = 1'b0; imemValid = 1'b0;
        #1;
        checkBit("rstdec.imemReq", imemReq, 1'b0);
        checkIdle("rstdec");
        exp_instret = 32'd0; exp_instr = 32'd0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkBit("rstdec.after.imemReq", imemReq, 1'b1);
        checkBit("rstdec.after.retired", retired, 1'b0);
        checkOutput("rstdec.after.instr", instr, 32'd0);
        checkOutput("rstdec.after.instret", instret, 32'd0);

        for (int n = 0; n < 80; n++) begin
            logic [6:0]  opc;
            logic [6:0]  f7;
            logic [4:0]  rd;
            logic [31:0] w;
            logic        z;
            case ($urandom_range(0, 3))
                0: opc = 7'h33;
                1: opc = 7'h13;
                2: opc = 7'h63;
                default: opc = 7'($urandom);
            endcase
            case ($urandom_range(0, 2))
                0: f7 = 7'h00;
                1: f7 = 7'h20;
                default: f7 = 7'($urandom);
            endcase
            rd = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            w = {f7, 10'($urandom), 3'($urandom), rd, opc};
            z = 1'($urandom_range(0, 1));
            applyStimulus(w, $urandom_range(0, 5), z, refDecode(w, z));
        end
        doReset();

        // Fetch timeout on the IMEM_TIMEOUT=4 instance
        @(negedge clk);
        reset_t = 1'b0; valid_t = 1'b0;
        #1;
        checkBit("to.rst.imemReq", imemReq_t, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset_t = 1'b1;
            #1;
            checkBit("to.wait.imemReq", imemReq_t, 1'b1);
            checkOutput("to.wait.fault", {30'b0, fault_t}, 32'd0);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            valid_t = 1'(i);
            #1;
            checkOutput("to.trap.fault", {30'b0, fault_t}, 32'd2);
            checkBit("to.trap.imemReq", imemReq_t, 1'b0);
            checkBit("to.trap.retired", retired_t, 1'b0);
        end
        @(negedge clk);
        reset_t = 1'b0; valid_t = 1'b0;
        #1;
        checkBit("to.rst2.imemReq", imemReq_t, 1'b0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            reset_t = 1'b1;
            valid_t = (i == 3);
            imemRdata = 32'h002081B3;
            #1;
            checkBit("to.limit.imemReq", imemReq_t, 1'b1);
        end
        @(negedge clk);
        valid_t = 1'b0;
        #1;
        checkOutput("to.limit.decode.fault", {30'b0, fault_t}, 32'd0);
        checkBit("to.limit.decode.imemReq", imemReq_t, 1'b0);
        checkOutput("to.limit.decode.instr", instr_t, 32'h002081B3);
        checkOutput("to.limit.decode.instret", instret_t, 32'd0);
        @(negedge clk);
        #1;
        checkBit("to.exec.retired", retired_t, 1'b1);
        checkBit("to.exec.pcWrite", pcWrite_t, 1'b1);
        checkBit("to.exec.regWrite", regWrite_t, 1'b1);
        checkOutput("to.exec.aluControl", {28'b0, aluControl_t}, 32'd0);
        checkBit("to.exec.isALUreg", isALUreg_t, 1'b1);
        checkBit("to.exec.isShamt", isShamt_t, 1'b0);
        checkBit("to.exec.pcSrcBranch", pcSrcBranch_t, 1'b0);
        @(negedge clk);
        #1;
        checkOutput("to.after.instret", instret_t, 32'd1);
        checkBit("to.after.imemReq", imemReq_t, 1'b1);
        checkOutput("to.after.fault", {30'b0, fault_t}, 32'd0);
        reset_t = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
